// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Brief    : Multi-port integer register file (NRD read / NWR write ports)
//            with a per-register pending scoreboard for RAW hazard detection.
//            Register 0 is hardwired to zero and can never be pending.
// Config   : REGFILE_BYPASS_EN - when defined, same-cycle writes are
//            forwarded to the read ports (write-first).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]       rd_data,
  output logic [NRD-1:0]            rd_pending,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR*$clog2(NREGS)-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]       wr_data,
  input  logic                      iss_en,
  input  logic [$clog2(NREGS)-1:0]  iss_addr,
  output logic                      any_pending
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // Next pending vector: writebacks clear, then issue sets (new producer wins).
  always_comb begin
    w_pending_nxt = r_pending;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
        w_pending_nxt[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en && (iss_addr != '0)) begin
      w_pending_nxt[iss_addr] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Register array and scoreboard; later write ports overwrite earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
          r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
      r_pending <= w_pending_nxt;
    end
  end

  // Combinational read ports with optional write-first forwarding.
  always_comb begin
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_d;
    logic            w_p;
    rd_data    = '0;
    rd_pending = '0;
    for (int k = 0; k < NRD; k++) begin
      w_a = rd_addr[k*AW +: AW];
      w_d = r_regs[w_a];
      w_p = r_pending[w_a];
`ifdef REGFILE_BYPASS_EN
      // Forwarded data is the value being written back, so it is not pending
      // this cycle; a same-cycle issue only shows up on the next cycle.
      for (int p = 0; p < NWR; p++) begin
        if (rst_n && wr_en[p] && (wr_addr[p*AW +: AW] == w_a)) begin
          w_d = wr_data[p*XLEN +: XLEN];
          w_p = 1'b0;
        end
      end
`else
      // Reads see only the registered array; same-cycle writes appear next cycle.
`endif
      if (w_a == '0) begin
        w_d = '0;
        w_p = 1'b0;
      end
      rd_data[k*XLEN +: XLEN] = w_d;
      rd_pending[k]           = w_p;
    end
  end

  // Any outstanding producer anywhere in the file.
  assign any_pending = |r_pending;

endmodule
`default_nettype wire
